// File: rtl/capp_array.sv
// capp_array: content-addressable parallel processor array. Each word is a capp_cell
// with its own masked comparator. A two-state sequencer executes one command per handshake.
module capp_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] wmask_i,
    input  logic [WIDTH-1:0] comp_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic [WIDTH-1:0] word_o,
    output logic             match_o
);
    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   word_q <= '0;
        else if (we_i) word_q <= (word_q & ~wmask_i) | (wdata_i & wmask_i);
    end

    assign word_o  = word_q;
    assign match_o = ((word_q ^ comp_i) & mask_i) == '0;
endmodule

module capp_array #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 100,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [1:0]        cmd_mode_i,
    input  logic [WIDTH-1:0]  cmd_data_i,
    input  logic [WIDTH-1:0]  cmd_mask_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    output logic              rd_valid_o,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic [DEPTH-1:0]  tags_o,
    output logic              some_o,
    output logic [ADDR_W-1:0] first_idx_o
);
    typedef enum logic [2:0] {
        OP_NOP, OP_LOAD, OP_SEARCH, OP_SET_ALL,
        OP_SELECT_FIRST, OP_WRITE_TAGGED, OP_READ_FIRST, OP_WRITE_ADDR
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [1:0]        mode;
        logic [WIDTH-1:0]  data;
        logic [WIDTH-1:0]  mask;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    typedef enum logic {IDLE, EXEC} state_e;

    state_e                       state_q;
    cmd_t                         cmd_q;
    logic                         ready_q, rd_valid_q;
    logic [WIDTH-1:0]             comp_q, mask_q, rd_data_q;
    logic [DEPTH-1:0]             tags_q, tags_d, match, we;
    logic [DEPTH-1:0][WIDTH-1:0]  words;
    logic [WIDTH-1:0]             wdata, wmask;
    logic [ADDR_W-1:0]            first_idx;
    logic                         some, exec;

    assign exec  = (state_q == EXEC);
    assign wdata = (cmd_q.op == OP_WRITE_ADDR) ? cmd_q.data : comp_q;
    assign wmask = (cmd_q.op == OP_WRITE_ADDR) ? {WIDTH{1'b1}} : mask_q;

    // Addresses at or beyond DEPTH select no cell, so out-of-range writes drop.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign we[i] = exec &
            (((cmd_q.op == OP_WRITE_TAGGED) && tags_q[i]) ||
             ((cmd_q.op == OP_WRITE_ADDR) && (cmd_q.addr == ADDR_W'(i))));
        capp_cell #(.WIDTH(WIDTH)) u_cell (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .we_i    (we[i]),
            .wdata_i (wdata),
            .wmask_i (wmask),
            .comp_i  (comp_q),
            .mask_i  (mask_q),
            .word_o  (words[i]),
            .match_o (match[i])
        );
    end

    always_comb begin
        first_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (tags_q[i]) first_idx = ADDR_W'(i);
    end
    assign some = |tags_q;

    always_comb begin
        tags_d = tags_q;
        case (cmd_q.op)
            OP_SEARCH: begin
                case (cmd_q.mode)
                    2'b01:   tags_d = tags_q & match;
                    2'b10:   tags_d = tags_q | match;
                    default: tags_d = match;
                endcase
            end
            OP_SET_ALL:      tags_d = '1;
            // Two's-complement trick isolates the lowest set bit; zero stays zero.
            OP_SELECT_FIRST: tags_d = tags_q & (~tags_q + 1'b1);
            default:         tags_d = tags_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            cmd_q      <= '0;
            comp_q     <= '0;
            mask_q     <= '0;
            tags_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid_i) begin
                    cmd_q   <= '{op: op_e'(cmd_op_i), mode: cmd_mode_i, data: cmd_data_i,
                                 mask: cmd_mask_i, addr: cmd_addr_i};
                    state_q <= EXEC;
                    ready_q <= 1'b0;
                end
                EXEC: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    tags_q  <= tags_d;
                    if (cmd_q.op == OP_LOAD) begin
                        comp_q <= cmd_q.data;
                        mask_q <= cmd_q.mask;
                    end
                    if (cmd_q.op == OP_READ_FIRST) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= some ? words[first_idx] : '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign tags_o      = tags_q;
    assign some_o      = some;
    assign first_idx_o = first_idx;
endmodule
